// File: rtl/one_bank_pkg.sv
// Shared types and constants for the one_bank light lane.
// Level range, prescaler sizing and the speed-to-period mapping live here.
package one_bank_pkg;

  localparam int NUM_LIGHTS = 5;
  localparam int LVL_W      = 3;
  localparam int SLOW_DIV   = 8;
  localparam int PRE_W      = $clog2(SLOW_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } bank_state_t;

  // Clock cycles per level step for each speed code.
  function automatic logic [PRE_W:0] period(input logic [1:0] speed);
    case (speed)
      2'b00:   period = (PRE_W+1)'(SLOW_DIV);
      2'b01:   period = (PRE_W+1)'(SLOW_DIV / 2);
      2'b10:   period = (PRE_W+1)'(SLOW_DIV / 4);
      default: period = (PRE_W+1)'(1);
    endcase
  endfunction

endpackage

// File: rtl/one_bank_cyber.sv
// Start/stop sequencer: registered start edge detect feeding an IDLE/RUN/HALT FSM.
// up is Moore (state register only); stop always outranks a start edge.
module cyber
  import one_bank_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic start,
  input  logic stop,
  output logic up
);

  bank_state_t state, state_nxt;
  logic        start_q;
  logic        start_rise;

  assign start_rise = start & ~start_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!stop && start_rise) state_nxt = RUN;
      RUN:     if (stop) state_nxt = HALT;
      HALT:    if (!stop && start_rise) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign up = (state == RUN);

endmodule

// File: rtl/one_bank_decoder.sv
// Thermometer decode of the level: light i is on when level exceeds i.
// Purely combinational; levels above NUM_LIGHTS saturate to all on.
module decoder
  import one_bank_pkg::*;
(
  input  logic [LVL_W-1:0]      level,
  output logic [NUM_LIGHTS-1:0] lights
);

  for (genvar i = 0; i < NUM_LIGHTS; i++) begin : g_light
    assign lights[i] = (level > LVL_W'(i));
  end

endmodule

// File: rtl/one_bank_inclight.sv
// Rate-divided level counter: steps level once per period while up, wrapping past NUM_LIGHTS.
// Prescaler clears whenever up drops, so a resume always waits a full period.
module incLight
  import one_bank_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             up,
  input  logic [1:0]       speed,
  output logic [LVL_W-1:0] level
);

  logic [PRE_W-1:0] prescaler;
  logic [PRE_W:0]   last;
  logic             tick;

  assign last = period(speed) - (PRE_W+1)'(1);
  // >= rather than == so a drop to a faster speed mid-count steps right away.
  assign tick = ({1'b0, prescaler} >= last);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      prescaler <= '0;
      level     <= '0;
    end else if (!up) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
      level     <= (level == LVL_W'(NUM_LIGHTS)) ? '0 : level + LVL_W'(1);
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

endmodule

// File: rtl/one_bank.sv
// One lane of the light-game display: sequencer -> rate counter -> thermometer decoder.
// out is decoded from registered level only, so it never glitches on input changes.
module one_bank
  import one_bank_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [1:0]            speed,
  input  logic                  start,
  input  logic                  stop,
  output logic [NUM_LIGHTS-1:0] out
);

  logic             up;
  logic [LVL_W-1:0] level;

  cyber u_cyber (
    .Clock (Clock),
    .Reset (Reset),
    .start (start),
    .stop  (stop),
    .up    (up)
  );

  incLight u_inclight (
    .Clock (Clock),
    .Reset (Reset),
    .up    (up),
    .speed (speed),
    .level (level)
  );

  decoder u_decoder (
    .level  (level),
    .lights (out)
  );

endmodule

// File: tb/tb_one_bank.sv
// Directed bench for one_bank: driver queues the expected light pattern per cycle,
// a negedge monitor pops and compares it against out.
module tb_one_bank;
  import one_bank_pkg::*;

  logic       Clock;
  logic       Reset;
  logic [1:0] speed;
  logic       start;
  logic       stop;
  logic [4:0] out;

  int tests = 0;
  int fails = 0;

  logic [4:0] exp_q[$];
  string      nm_q[$];

  one_bank dut (
    .Clock (Clock),
    .Reset (Reset),
    .speed (speed),
    .start (start),
    .out   (out),
    .stop  (stop)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: out=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the out value expected after the next edge.
  task automatic cyc(input logic st, input logic sp, input logic [1:0] spd,
                     input logic [4:0] exp, input string nm);
    @(negedge Clock);
    start = st;
    stop  = sp;
    speed = spd;
    @(posedge Clock);
    #1;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
  endtask

  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      string      n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      check(n, out, e);
    end
  end

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    speed = 2'b00;
    #12;
    check("reset_out", out, 5'b00000);
    @(negedge Clock);
    Reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'b00, 5'b00000, "idle");

    // 2: fastest speed, one-clock start pulse, full climb and wrap
    cyc(1'b1, 1'b0, 2'b11, 5'b00000, "fast_arm");
    cyc(1'b0, 1'b0, 2'b11, 5'b00001, "fast_l1");
    cyc(1'b0, 1'b0, 2'b11, 5'b00011, "fast_l2");
    cyc(1'b0, 1'b0, 2'b11, 5'b00111, "fast_l3");
    cyc(1'b0, 1'b0, 2'b11, 5'b01111, "fast_l4");
    cyc(1'b0, 1'b0, 2'b11, 5'b11111, "fast_l5");
    cyc(1'b0, 1'b0, 2'b11, 5'b00000, "fast_wrap");
    cyc(1'b0, 1'b0, 2'b00, 5'b00000, "slow_switch");
    cyc(1'b0, 1'b1, 2'b00, 5'b00000, "halt_l0");
    cyc(1'b0, 1'b0, 2'b00, 5'b00000, "halt_hold");

    // 3: slowest speed, start held high, first step 8 clocks after RUN
    cyc(1'b1, 1'b0, 2'b00, 5'b00000, "slow_arm");
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 2'b00, 5'b00000, "slow_wait");
    cyc(1'b1, 1'b0, 2'b00, 5'b00001, "slow_step");
    cyc(1'b1, 1'b1, 2'b00, 5'b00001, "slow_halt");
    cyc(1'b0, 1'b0, 2'b00, 5'b00001, "slow_hold");

    // 4: speed 10 up to level 2, stop for 6 clocks, resume
    cyc(1'b1, 1'b0, 2'b10, 5'b00001, "mid_arm");
    cyc(1'b0, 1'b0, 2'b10, 5'b00001, "mid_wait");
    cyc(1'b0, 1'b0, 2'b10, 5'b00011, "mid_l2");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 2'b10, 5'b00011, "stop_freeze");
    cyc(1'b1, 1'b0, 2'b10, 5'b00011, "resume_arm");
    cyc(1'b0, 1'b0, 2'b10, 5'b00011, "resume_wait");
    cyc(1'b0, 1'b0, 2'b10, 5'b00111, "resume_l3");
    cyc(1'b0, 1'b0, 2'b10, 5'b00111, "run_wait");
    cyc(1'b0, 1'b0, 2'b10, 5'b01111, "run_l4");

    // 6a: async reset mid-cycle at level 4
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset", out, 5'b00000);
    @(negedge Clock);
    Reset = 1'b0;

    // 5: stop and start edge together from IDLE
    cyc(1'b1, 1'b1, 2'b11, 5'b00000, "stop_wins");
    cyc(1'b0, 1'b0, 2'b11, 5'b00000, "stop_wins_idle");
    cyc(1'b0, 1'b0, 2'b11, 5'b00000, "stop_wins_idle2");
    tests++;
    if (dut.u_cyber.state !== IDLE) begin
      fails++;
      $display("FAIL state_idle: state=%0d expected=%0d", dut.u_cyber.state, IDLE);
    end

    // 6b: speed 00 -> 11 with prescaler at 6 steps on the next edge
    cyc(1'b1, 1'b0, 2'b00, 5'b00000, "sw_arm");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 2'b00, 5'b00000, "sw_count");
    cyc(1'b0, 1'b0, 2'b11, 5'b00001, "sw_step");
    cyc(1'b0, 1'b0, 2'b11, 5'b00011, "sw_next");

    @(negedge Clock);
    @(negedge Clock);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
